// File: rtl/asyn_fifo_pkg.sv
// ----------------------------------------------------------------------------
// asyn_fifo_pkg
//   Shared definitions for the asynchronous FIFO (write ctrl, read ctrl, top).
//   - ADDR_WIDTH_DEFAULT : default address width (depth = 2**ADDR_WIDTH)
//   - bin2gray / gray2bin: pointer code conversions. They operate on a
//     PTR_MAX_W-bit container; callers zero-extend their pointer into it and
//     size-cast the result back. Leading zeros do not disturb either
//     conversion, so one pair of functions serves every pointer width.
// ----------------------------------------------------------------------------
package asyn_fifo_pkg;

    localparam int ADDR_WIDTH_DEFAULT = 6;
    localparam int PTR_MAX_W          = 32;

    typedef logic [PTR_MAX_W-1:0] ptr_max_t;

    function automatic ptr_max_t bin2gray(input ptr_max_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_max_t gray2bin(input ptr_max_t gray);
        ptr_max_t bin;
        bin[PTR_MAX_W-1] = gray[PTR_MAX_W-1];
        for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/asyn_fifo_read_ctrl.sv
// ----------------------------------------------------------------------------
// asyn_fifo_read_ctrl
//   Read-domain controller of the async FIFO. Owns the read pointer, drives
//   the RAM read address and derives empty / almost-empty / level from the
//   already-synchronized Gray write pointer.
//
// Ports
//   read_clk           in   read-domain clock
//   read_rst_n         in   asynchronous active-low reset
//   read_en            in   pop request
//   sync_write_to_read in   Gray write pointer, synchronized into read_clk
//   read_addr          out  RAM read address (low bits of binary read ptr)
//   read_ptr           out  registered Gray read pointer (to write domain)
//   read_empty         out  FIFO empty
//   read_almost_empty  out  level <= ALMOST_EMPTY_TH
//   read_level         out  entries available, 0..2**ADDR_WIDTH
//   read_valid         out  RAM data for the previous accepted pop is valid
//   read_underflow     out  1-cycle pulse after a pop request while empty
// ----------------------------------------------------------------------------
module asyn_fifo_read_ctrl
    import asyn_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH      = ADDR_WIDTH_DEFAULT,
    parameter int ALMOST_EMPTY_TH = 4
) (
    input  logic                  read_clk,
    input  logic                  read_rst_n,
    input  logic                  read_en,
    input  logic [ADDR_WIDTH:0]   sync_write_to_read,
    output logic [ADDR_WIDTH-1:0] read_addr,
    output logic [ADDR_WIDTH:0]   read_ptr,
    output logic                  read_empty,
    output logic                  read_almost_empty,
    output logic [ADDR_WIDTH:0]   read_level,
    output logic                  read_valid,
    output logic                  read_underflow
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_TH = PW'(ALMOST_EMPTY_TH);

    logic          accept;
    logic [PW-1:0] rbin;
    logic [PW-1:0] rbin_next;
    logic [PW-1:0] rgray_next;
    logic [PW-1:0] wbin;
    logic [PW-1:0] level_next;

    // Next-state logic: a pop and a synced write-pointer change in the same
    // cycle both feed these equations, so neither event is lost.
    always_comb begin
        accept     = read_en & ~read_empty;
        rbin_next  = rbin + {{(PW-1){1'b0}}, accept};
        rgray_next = PW'(bin2gray(PTR_MAX_W'(rbin_next)));
        wbin       = PW'(gray2bin(PTR_MAX_W'(sync_write_to_read)));
        // Modulo subtraction with the wrap bit yields 0..2**ADDR_WIDTH.
        level_next = wbin - rbin_next;
    end

    // Register bank: flags are computed from the post-pop pointer so popping
    // the last entry raises empty on the same edge.
    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            rbin              <= '0;
            read_ptr          <= '0;
            read_empty        <= 1'b1;
            read_almost_empty <= 1'b1;
            read_level        <= '0;
            read_valid        <= 1'b0;
            read_underflow    <= 1'b0;
        end else begin
            rbin              <= rbin_next;
            read_ptr          <= rgray_next;
            read_empty        <= (rgray_next == sync_write_to_read);
            read_almost_empty <= (level_next <= AE_TH);
            read_level        <= level_next;
            read_valid        <= accept;
            read_underflow    <= read_en & read_empty;
        end
    end

    assign read_addr = rbin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_asyn_fifo_read_ctrl.sv
module tb_asyn_fifo_read_ctrl;

    localparam int AW = 2;
    localparam int TH = 1;

    logic          read_clk = 1'b0;
    logic          read_rst_n;
    logic          read_en;
    logic [AW:0]   sync_write_to_read;
    logic [AW-1:0] read_addr;
    logic [AW:0]   read_ptr;
    logic          read_empty;
    logic          read_almost_empty;
    logic [AW:0]   read_level;
    logic          read_valid;
    logic          read_underflow;

    int n_checks = 0;
    int n_pass   = 0;

    asyn_fifo_read_ctrl #(.ADDR_WIDTH(AW), .ALMOST_EMPTY_TH(TH)) dut (
        .read_clk           (read_clk),
        .read_rst_n         (read_rst_n),
        .read_en            (read_en),
        .sync_write_to_read (sync_write_to_read),
        .read_addr          (read_addr),
        .read_ptr           (read_ptr),
        .read_empty         (read_empty),
        .read_almost_empty  (read_almost_empty),
        .read_level         (read_level),
        .read_valid         (read_valid),
        .read_underflow     (read_underflow)
    );

    always #5 read_clk = ~read_clk;

    typedef struct {
        logic          rst_n;
        logic          en;
        logic [AW:0]   w;
        logic [AW-1:0] addr;
        logic [AW:0]   ptr;
        logic          empty;
        logic          aempty;
        logic [AW:0]   level;
        logic          valid;
        logic          uflow;
    } vec_t;

    vec_t vecs[$];

    // {addr, ptr, empty, aempty, level, valid, uflow}
    localparam logic [11:0] RESET_OUTS = {2'd0, 3'b000, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0};

    function automatic logic [11:0] outs();
        return {read_addr, read_ptr, read_empty, read_almost_empty,
                read_level, read_valid, read_underflow};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge read_clk);
        #1;
    endtask

    initial begin
        logic [AW:0] prev_ptr;

        // ---------------- reset and underflow corner cases ----------------
        read_rst_n = 1'b0;
        read_en = 1'b0;
        sync_write_to_read = '0;
        repeat (2) tick();
        chk("reset_outs", 32'(outs()), 32'(RESET_OUTS));
        read_rst_n = 1'b1;

        sync_write_to_read = 3'b011;            // 2 entries written
        tick();
        chk("fill2_level", 32'(read_level), 32'd2);
        chk("fill2_flags", 32'({read_empty, read_almost_empty}), 32'b00);
        read_en = 1'b1;
        tick();
        chk("pop_inflight", 32'({read_valid, read_addr, read_ptr, read_level}),
            32'({1'b1, 2'd1, 3'b001, 3'd1}));
        #3 read_rst_n = 1'b0;                   // mid-cycle asynchronous reset
        #1 chk("async_reset_outs", 32'(outs()), 32'(RESET_OUTS));
        sync_write_to_read = '0;
        read_en = 1'b1;
        #2 read_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("uflow_hold_%0d", i),
                32'({read_underflow, read_valid, read_empty, read_addr, read_ptr}),
                32'({1'b1, 1'b0, 1'b1, 2'd0, 3'b000}));
        end
        read_en = 1'b0;
        tick();
        chk("uflow_release", 32'(read_underflow), 32'd0);

        // ---------------- directed vector table ----------------
        //                 rst en  w       addr ptr    e  ae lvl  v  u
        // fill to 3, drain with 3 pops, then one idle-pop underflow check
        vecs.push_back('{1'b1, 1'b1, 3'b000, 2'd0, 3'b000, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 2'd0, 3'b000, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b010, 2'd1, 3'b001, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b010, 2'd2, 3'b011, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b010, 2'd3, 3'b010, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'b010, 2'd3, 3'b010, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0});
        // reset, then full level (Gray 4) with rbin=0, then a pop from full
        vecs.push_back('{1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'b110, 2'd0, 3'b000, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b110, 2'd1, 3'b001, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0});
        // reset, level 1, then 8 pops with a simultaneous +1 write (wrap)
        vecs.push_back('{1'b0, 1'b0, 3'b000, 2'd0, 3'b000, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'b001, 2'd0, 3'b000, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b011, 2'd1, 3'b001, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b010, 2'd2, 3'b011, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b110, 2'd3, 3'b010, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b111, 2'd0, 3'b110, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b101, 2'd1, 3'b111, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b100, 2'd2, 3'b101, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b000, 2'd3, 3'b100, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b001, 2'd0, 3'b000, 1'b0, 1'b1, 3'd1, 1'b1, 1'b0});
        // 9th pop drains the last entry, then a pop on empty underflows
        vecs.push_back('{1'b1, 1'b1, 3'b001, 2'd1, 3'b001, 1'b1, 1'b1, 3'd0, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b001, 2'd1, 3'b001, 1'b1, 1'b1, 3'd0, 1'b0, 1'b1});

        for (int i = 0; i < vecs.size(); i++) begin
            prev_ptr           = read_ptr;
            read_rst_n         = vecs[i].rst_n;
            read_en            = vecs[i].en;
            sync_write_to_read = vecs[i].w;
            tick();
            chk($sformatf("vec_%0d", i), 32'(outs()),
                32'({vecs[i].addr, vecs[i].ptr, vecs[i].empty, vecs[i].aempty,
                     vecs[i].level, vecs[i].valid, vecs[i].uflow}));
            if (i >= 11 && i <= 19)
                chk($sformatf("gray_step_%0d", i), 32'($countones(read_ptr ^ prev_ptr)), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
